// File: rtl/apb_byte_mem_if.sv
// APB bus bundle between a master and apb_byte_mem.
// Clock and reset stay plain ports on the modules that use this interface.
interface apb_byte_mem_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PRDATA,
    output PREADY,
    output PSLVERR
  );

endinterface

// File: rtl/apb_byte_mem.sv
// Byte-addressed APB slave memory with big-endian word access at any byte offset,
// programmable wait states and PSLVERR on accesses that run past the end of storage.
module apb_byte_mem #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_BYTES   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_byte_mem_if.slave  bus
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH + 1)'(NBYTES);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(NUM_BYTES);
  localparam logic [3:0]          WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } phase_t;

  phase_t                state_q;
  phase_t                state_d;
  phase_t                phase;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic                  complete;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            mem [NUM_BYTES];

  function automatic logic [IDX_W-1:0] lane_addr(input logic [ADDR_WIDTH-1:0] base,
                                                 input int                    lane);
    logic [ADDR_WIDTH-1:0] sum;
    sum = base + ADDR_WIDTH'(lane);
    return IDX_W'(sum);
  endfunction

  // The setup phase is recognised from the live bus, so a new transfer may begin
  // the cycle right after a completion without an idle gap.
  assign phase = (bus.PSEL && !bus.PENABLE) ? SETUP : state_q;

  assign in_range = ({1'b0, bus.PADDR} + SPAN) <= LIMIT;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (phase)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != WS) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // PADDR lands on the MSB lane; successive bytes fill towards the LSB.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NBYTES; i++) begin
      rd_word[DATA_WIDTH-1-8*i -: 8] = mem[lane_addr(bus.PADDR, i)];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mem <= '{default: 8'h00};
    end else if (complete && bus.PWRITE && in_range) begin
      for (int i = 0; i < NBYTES; i++) begin
        mem[lane_addr(bus.PADDR, i)] <= bus.PWDATA[DATA_WIDTH-1-8*i -: 8];
      end
    end
  end

  assign bus.PREADY  = complete;
  assign bus.PSLVERR = complete && !in_range;
  assign bus.PRDATA  = (complete && !bus.PWRITE && in_range) ? rd_word : '0;

endmodule

// File: tb/tb_apb_byte_mem.sv
// Directed bench for apb_byte_mem: one instance with one wait state, one with none.
// Each test task drives its own transfers and checks against hand-computed values.
module tb_apb_byte_mem;

  localparam int AW = 13;
  localparam int DW = 32;

  logic PCLK = 1'b0;
  logic PRESETn;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 PCLK = ~PCLK;

  apb_byte_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_ws1 ();
  apb_byte_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_ws0 ();

  apb_byte_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BYTES  (256),
    .WAIT_STATES(1)
  ) dut_ws1 (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus_ws1.slave)
  );

  apb_byte_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BYTES  (256),
    .WAIT_STATES(0)
  ) dut_ws0 (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus_ws0.slave)
  );

  task automatic drive(input bit fast, input logic sel, input logic en, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (fast) begin
      bus_ws0.PSEL = sel; bus_ws0.PENABLE = en; bus_ws0.PWRITE = wr;
      bus_ws0.PADDR = addr; bus_ws0.PWDATA = wdata;
    end else begin
      bus_ws1.PSEL = sel; bus_ws1.PENABLE = en; bus_ws1.PWRITE = wr;
      bus_ws1.PADDR = addr; bus_ws1.PWDATA = wdata;
    end
  endtask

  task automatic sample(input bit fast, output logic rdy, output logic err,
                        output logic [DW-1:0] rd);
    if (fast) begin
      rdy = bus_ws0.PREADY; err = bus_ws0.PSLVERR; rd = bus_ws0.PRDATA;
    end else begin
      rdy = bus_ws1.PREADY; err = bus_ws1.PSLVERR; rd = bus_ws1.PRDATA;
    end
  endtask

  task automatic bus_idle();
    @(negedge PCLK);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // One full transfer; cycles counts setup through completion inclusive.
  task automatic apb_xfer(input bit fast, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rd,
                          output logic err, output int cycles, output logic setup_rdy);
    logic rdy;
    @(negedge PCLK);
    drive(fast, 1'b1, 1'b0, wr, addr, wdata);
    #1 sample(fast, setup_rdy, err, rd);
    @(negedge PCLK);
    drive(fast, 1'b1, 1'b1, wr, addr, wdata);
    #1 sample(fast, rdy, err, rd);
    cycles = 2;
    while (rdy !== 1'b1 && cycles < 20) begin
      @(negedge PCLK);
      #1 sample(fast, rdy, err, rd);
      cycles++;
    end
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL xfer_timeout addr=%h: PREADY still %b after %0d cycles, required 1", addr, rdy, cycles);
    end
  endtask

  task automatic test_reset();
    logic rdy, err;
    logic [DW-1:0] rd;
    int cyc;
    logic sr;
    PRESETn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #2 PRESETn = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    for (int f = 0; f < 2; f++) begin
      sample(f[0], rdy, err, rd);
      vectors++;
      if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pready dut%0d: got %b required 0", f, rdy); end
      vectors++;
      if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pslverr dut%0d: got %b required 0", f, err); end
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_prdata dut%0d: got %h required 00000000", f, rd); end
    end
    PRESETn = 1'b1;
    apb_xfer(1'b0, 1'b0, 13'h010, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_storage: got %h required 00000000", rd); end
    bus_idle();
  endtask

  task automatic test_aligned();
    logic [DW-1:0] rd;
    logic err, sr;
    int cyc;
    apb_xfer(1'b0, 1'b1, 13'h010, 32'hDEADBEEF, rd, err, cyc, sr);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL aligned_wr_err: got %b required 0", err); end
    vectors++;
    if (cyc !== 3) begin miscompares++; $display("[TB] FAIL aligned_wr_cycles: got %0d required 3", cyc); end
    vectors++;
    if (sr !== 1'b0) begin miscompares++; $display("[TB] FAIL aligned_setup_ready: got %b required 0", sr); end
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL aligned_wr_prdata: got %h required 00000000", rd); end
    apb_xfer(1'b0, 1'b0, 13'h010, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL aligned_rd_data: got %h required deadbeef", rd); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL aligned_rd_err: got %b required 0", err); end
    vectors++;
    if (cyc !== 3) begin miscompares++; $display("[TB] FAIL aligned_rd_cycles: got %0d required 3", cyc); end
    bus_idle();
  endtask

  task automatic test_unaligned();
    logic [DW-1:0] rd;
    logic err, sr;
    int cyc;
    apb_xfer(1'b0, 1'b1, 13'h000, 32'h11223344, rd, err, cyc, sr);
    apb_xfer(1'b0, 1'b1, 13'h002, 32'hAABBCCDD, rd, err, cyc, sr);
    apb_xfer(1'b0, 1'b0, 13'h001, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h22AABBCC) begin miscompares++; $display("[TB] FAIL unaligned_rd1: got %h required 22aabbcc", rd); end
    apb_xfer(1'b0, 1'b0, 13'h000, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h1122AABB) begin miscompares++; $display("[TB] FAIL unaligned_rd0: got %h required 1122aabb", rd); end
    apb_xfer(1'b0, 1'b0, 13'h003, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'hBBCCDD00) begin miscompares++; $display("[TB] FAIL unaligned_rd3: got %h required bbccdd00", rd); end
    bus_idle();
  endtask

  task automatic test_boundary();
    logic [DW-1:0] rd;
    logic err, sr;
    int cyc;
    apb_xfer(1'b0, 1'b1, 13'h0FC, 32'h01020304, rd, err, cyc, sr);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL bound_wr_fc_err: got %b required 0", err); end
    apb_xfer(1'b0, 1'b0, 13'h0FC, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h01020304) begin miscompares++; $display("[TB] FAIL bound_rd_fc: got %h required 01020304", rd); end
    apb_xfer(1'b0, 1'b1, 13'h0FD, 32'hA5A5A5A5, rd, err, cyc, sr);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL bound_wr_fd_err: got %b required 1", err); end
    vectors++;
    if (cyc !== 3) begin miscompares++; $display("[TB] FAIL bound_wr_fd_cycles: got %0d required 3", cyc); end
    apb_xfer(1'b0, 1'b0, 13'h0FC, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h01020304) begin miscompares++; $display("[TB] FAIL bound_fd_unchanged: got %h required 01020304", rd); end
    apb_xfer(1'b0, 1'b0, 13'h0FD, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL bound_rd_fd_data: got %h required 00000000", rd); end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL bound_rd_fd_err: got %b required 1", err); end
    apb_xfer(1'b0, 1'b0, 13'h1FFF, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL bound_rd_wrap_err: got %b required 1", err); end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [DW-1:0] rd;
    logic err, sr, rdy;
    int cyc;
    apb_xfer(1'b0, 1'b1, 13'h020, 32'h55667788, rd, err, cyc, sr);
    @(negedge PCLK);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 13'h020, 32'hFFFFFFFF);
    @(negedge PCLK);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 13'h020, 32'hFFFFFFFF);
    #1 sample(1'b0, rdy, err, rd);
    vectors++;
    if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_wait_ready: got %b required 0", rdy); end
    @(negedge PCLK);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 13'h020, 32'hFFFFFFFF);
    #1 sample(1'b0, rdy, err, rd);
    vectors++;
    if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_drop_ready: got %b required 0", rdy); end
    bus_idle();
    apb_xfer(1'b0, 1'b0, 13'h020, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h55667788) begin miscompares++; $display("[TB] FAIL abort_rd: got %h required 55667788", rd); end
    bus_idle();
  endtask

  task automatic test_idle_strobe();
    logic [DW-1:0] rd;
    logic err, sr, rdy;
    int cyc;
    @(negedge PCLK);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 13'h030, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      #1 sample(1'b0, rdy, err, rd);
      vectors++;
      if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL strobe_ready cyc%0d: got %b required 0", k, rdy); end
      @(negedge PCLK);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    apb_xfer(1'b0, 1'b0, 13'h030, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL strobe_no_write: got %h required 00000000", rd); end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    logic err, sr, rdy;
    int cyc;
    @(negedge PCLK);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 13'h040, 32'hCAFEF00D);
    @(negedge PCLK);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 13'h040, 32'hCAFEF00D);
    @(negedge PCLK);
    #1 sample(1'b0, rdy, err, rd);
    vectors++;
    if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_pre_ready: got %b required 1", rdy); end
    #1 PRESETn = 1'b0;
    #1 sample(1'b0, rdy, err, rd);
    vectors++;
    if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_ready: got %b required 0", rdy); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_err: got %b required 0", err); end
    @(negedge PCLK);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    bus_idle();
    apb_xfer(1'b0, 1'b0, 13'h040, 32'h0, rd, err, cyc, sr);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL rstmid_rd: got %h required 00000000", rd); end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd, data;
    logic err, sr;
    int cyc;
    for (int i = 0; i < 64; i++) begin
      data = $urandom;
      apb_xfer(1'b1, 1'b1, AW'(i), data, rd, err, cyc, sr);
      vectors++;
      if (cyc !== 2 || sr !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_wr_len @%0d: got %0d cycles setup_ready=%b required 2 cycles setup_ready=0", i, cyc, sr);
      end
      apb_xfer(1'b1, 1'b0, AW'(i), 32'h0, rd, err, cyc, sr);
      vectors++;
      if (rd !== data) begin miscompares++; $display("[TB] FAIL b2b_rd @%0d: got %h required %h", i, rd, data); end
      vectors++;
      if (cyc !== 2 || sr !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_rd_len @%0d: got %0d cycles setup_ready=%b required 2 cycles setup_ready=0", i, cyc, sr);
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_boundary();
    test_abort();
    test_idle_strobe();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
